// File: rtl/frame_line_fetch.sv
// frame_line_fetch: fetches one display line from DDR2 into a ping-pong line buffer.
//   A rising edge on req_rd_ddr starts a fetch of req_ddr_addr_row. The line is read in
//   BURST_LEN-beat bursts and written to bank row[0] of a 2048x16 line buffer. The display
//   reads that buffer through linebuf_rd_*.
//   A new request while a fetch is running aborts it. Any beats still in flight are drained
//   and discarded, and the fetch restarts at column 0 of the new row.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_rd_ddr, req_ddr_addr_row row fetch request (edge-detected) and row number
//   ddr_rd_req/addr/ack         DDR read command handshake, addr = {row, column}
//   ddr_rd_data_valid/data      DDR read data beats
//   linebuf_rd_en/addr/data     display read port, addr = {bank, column}, 1-cycle latency
//   line_ready                  one-cycle pulse when a full line is written
//   fetch_busy                  fetch engine not idle
//   fetch_overrun_cnt           saturating count of requests received while busy
// Build option: define FRAME_LINE_FETCH_OVERRUN_CNT_EN to enable fetch_overrun_cnt.
//   Without it the output is tied to zero.
module frame_line_fetch #(
  parameter int unsigned LINE_WORDS = 640,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ROW_W      = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_rd_ddr,
  input  logic [ROW_W-1:0]     req_ddr_addr_row,
  output logic                 ddr_rd_req,
  output logic [ROW_W+10-1:0]  ddr_rd_addr,
  input  logic                 ddr_rd_ack,
  input  logic                 ddr_rd_data_valid,
  input  logic [15:0]          ddr_rd_data,
  input  logic                 linebuf_rd_en,
  input  logic [10:0]          linebuf_rd_addr,
  output logic [15:0]          linebuf_rd_data,
  output logic                 line_ready,
  output logic                 fetch_busy,
  output logic [7:0]           fetch_overrun_cnt
);

  localparam int unsigned COL_W   = 11;
  localparam int unsigned CIDX_W  = 10;
  localparam int unsigned BUF_AW  = 11;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BUF_DEPTH = 2 ** BUF_AW;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BURST_LEN);
  localparam logic [COL_W-1:0]  COL_END   = COL_W'(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t              state, state_n;
  logic                req_1d;
  logic [ROW_W-1:0]    row_r, row_n;
  logic                bank_r, bank_n;
  logic [COL_W-1:0]    col_r, col_n;
  logic [BEAT_W-1:0]   beat_cnt, beat_n;

  logic                req_rise_c;
  logic                last_beat_c;
  logic                wr_en_c;
  logic [BUF_AW-1:0]   wr_addr_c;

  logic [DATA_W-1:0]   line_mem [BUF_DEPTH];

  assign req_rise_c  = req_rd_ddr & ~req_1d;
  assign last_beat_c = (beat_cnt == BEAT_LAST);

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    row_n   = row_r;
    bank_n  = bank_r;
    col_n   = col_r;
    beat_n  = beat_cnt;

    if (req_rise_c) begin
      row_n  = req_ddr_addr_row;
      bank_n = req_ddr_addr_row[0];
    end

    case (state)
      S_IDLE: begin
        if (req_rise_c) begin
          state_n = S_CMD;
          col_n   = '0;
          beat_n  = '0;
        end
      end

      S_CMD: begin
        beat_n = '0;
        if (req_rise_c) begin
          col_n = '0;
          // A command acked in the same cycle is already in flight; its beats must be drained.
          if (ddr_rd_ack) state_n = S_DRAIN;
        end else if (ddr_rd_ack) begin
          state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (ddr_rd_data_valid) begin
          if (last_beat_c) begin
            beat_n = '0;
            if (req_rise_c) begin
              state_n = S_CMD;
              col_n   = '0;
            end else begin
              col_n   = col_r + COL_STEP;
              state_n = (COL_W'(col_r + COL_STEP) == COL_END) ? S_DONE : S_CMD;
            end
          end else begin
            beat_n = beat_cnt + BEAT_W'(1);
            if (req_rise_c) begin
              state_n = S_DRAIN;
              col_n   = '0;
            end
          end
        end else if (req_rise_c) begin
          state_n = S_DRAIN;
          col_n   = '0;
        end
      end

      S_DONE: begin
        col_n   = '0;
        state_n = req_rise_c ? S_CMD : S_IDLE;
      end

      S_DRAIN: begin
        col_n = '0;
        if (ddr_rd_data_valid) begin
          if (last_beat_c) begin
            beat_n  = '0;
            state_n = S_CMD;
          end else begin
            beat_n = beat_cnt + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_1d      <= 1'b0;
      row_r       <= '0;
      bank_r      <= 1'b0;
      col_r       <= '0;
      beat_cnt    <= '0;
      ddr_rd_req  <= 1'b0;
      ddr_rd_addr <= '0;
      line_ready  <= 1'b0;
      fetch_busy  <= 1'b0;
    end else begin
      state       <= state_n;
      req_1d      <= req_rd_ddr;
      row_r       <= row_n;
      bank_r      <= bank_n;
      col_r       <= col_n;
      beat_cnt    <= beat_n;
      ddr_rd_req  <= (state_n == S_CMD);
      ddr_rd_addr <= {row_n, col_n[CIDX_W-1:0]};
      line_ready  <= (state_n == S_DONE);
      fetch_busy  <= (state_n != S_IDLE);
    end
  end

`ifdef FRAME_LINE_FETCH_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt, ovr_cnt_n;

  // Saturating count of requests that arrive while a fetch is running
  always_comb begin
    ovr_cnt_n = ovr_cnt;
    if (req_rise_c && (state != S_IDLE) && (ovr_cnt != 8'hFF))
      ovr_cnt_n = ovr_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovr_cnt <= 8'h00;
    else        ovr_cnt <= ovr_cnt_n;
  end

  assign fetch_overrun_cnt = ovr_cnt;
`else
  assign fetch_overrun_cnt = 8'h00;
`endif

  // Line buffer write: only beats of an accepted burst of the current row
  assign wr_en_c   = rst_n & (state == S_DATA) & ddr_rd_data_valid;
  assign wr_addr_c = {bank_r, CIDX_W'(col_r[CIDX_W-1:0] + CIDX_W'(beat_cnt))};

  always_ff @(posedge clk) begin
    if (wr_en_c) line_mem[wr_addr_c] <= ddr_rd_data;
  end

  // Read port: read-first, holds last value while not enabled
  always_ff @(posedge clk) begin
    if (!rst_n)             linebuf_rd_data <= '0;
    else if (linebuf_rd_en) linebuf_rd_data <= line_mem[linebuf_rd_addr];
  end

endmodule

// File: tb/tb_frame_line_fetch.sv
// Testbench for frame_line_fetch: scripted DDR responder with command and read-data scoreboards.
module tb_frame_line_fetch;

  localparam int unsigned ROW_W  = 13;
  localparam int unsigned NBURST = 80;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_rd_ddr;
  logic [ROW_W-1:0]   req_ddr_addr_row;
  logic               ddr_rd_req;
  logic [ROW_W+9:0]   ddr_rd_addr;
  logic               ddr_rd_ack;
  logic               ddr_rd_data_valid;
  logic [15:0]        ddr_rd_data;
  logic               linebuf_rd_en;
  logic [10:0]        linebuf_rd_addr;
  logic [15:0]        linebuf_rd_data;
  logic               line_ready;
  logic               fetch_busy;
  logic [7:0]         fetch_overrun_cnt;

  frame_line_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_rd_ddr        (req_rd_ddr),
    .req_ddr_addr_row  (req_ddr_addr_row),
    .ddr_rd_req        (ddr_rd_req),
    .ddr_rd_addr       (ddr_rd_addr),
    .ddr_rd_ack        (ddr_rd_ack),
    .ddr_rd_data_valid (ddr_rd_data_valid),
    .ddr_rd_data       (ddr_rd_data),
    .linebuf_rd_en     (linebuf_rd_en),
    .linebuf_rd_addr   (linebuf_rd_addr),
    .linebuf_rd_data   (linebuf_rd_data),
    .line_ready        (line_ready),
    .fetch_busy        (fetch_busy),
    .fetch_overrun_cnt (fetch_overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int lr_cnt = 0;

  logic [ROW_W+9:0] exp_cmd_q [$];
  logic [15:0]      exp_rd_q  [$];
  logic [15:0]      ref_mem   [0:2047];

  always @(negedge clk) if (rst_n && line_ready) lr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int row, input int col);
    return 16'((row * 16'h0111) ^ (col * 7) ^ 16'h3C5A);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmds(input int row, input int n);
    for (int b = 0; b < n; b++) exp_cmd_q.push_back({ROW_W'(row), 10'(b * 8)});
  endtask

  task automatic pulse_req(input int row);
    req_rd_ddr       = 1'b1;
    req_ddr_addr_row = ROW_W'(row);
    step();
    req_rd_ddr = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!ddr_rd_req && n < 50) begin
      step();
      n++;
    end
    check("req_timeout", 32'(ddr_rd_req), 32'd1);
  endtask

  // Accept one command after ack_delay stall cycles, comparing its address to the scoreboard
  task automatic issue(input int ack_delay);
    logic [ROW_W+9:0] a0;
    logic [ROW_W+9:0] exp;
    wait_req();
    a0 = ddr_rd_addr;
    for (int i = 0; i < ack_delay; i++) begin
      step();
      check("stall_req", 32'(ddr_rd_req), 32'd1);
      check("stall_addr", 32'(ddr_rd_addr), 32'(a0));
    end
    exp = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : '1;
    check("cmd_addr", 32'(ddr_rd_addr), 32'(exp));
    ddr_rd_ack = 1'b1;
    step();
    ddr_rd_ack = 1'b0;
    check("req_drop", 32'(ddr_rd_req), 32'd0);
  endtask

  task automatic beats(input int row, input int col, input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = pat(row, col + i);
      if (keep) ref_mem[{row[0], 10'(col + i)}] = ddr_rd_data;
      step();
    end
    ddr_rd_data_valid = 1'b0;
    ddr_rd_data       = 16'h0;
  endtask

  task automatic fetch(input int row, input int first_b, input int delay0);
    for (int b = first_b; b < NBURST; b++) begin
      issue((b == first_b) ? delay0 : 0);
      beats(row, b * 8, 8, 1'b1);
    end
  endtask

  task automatic readback(input int base, input int n);
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      linebuf_rd_en   = 1'b1;
      linebuf_rd_addr = 11'(base + i);
      exp_rd_q.push_back(ref_mem[base + i]);
      step();
      exp = exp_rd_q.pop_front();
      check("rd_data", 32'(linebuf_rd_data), 32'(exp));
    end
    linebuf_rd_en = 1'b0;
    step();
    step();
    check("rd_hold", 32'(linebuf_rd_data), 32'(ref_mem[base + n - 1]));
  endtask

  task automatic check_reset_outputs();
    check("rst_req",  32'(ddr_rd_req), 32'd0);
    check("rst_addr", 32'(ddr_rd_addr), 32'd0);
    check("rst_lr",   32'(line_ready), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_ovr",  32'(fetch_overrun_cnt), 32'd0);
    check("rst_rd",   32'(linebuf_rd_data), 32'd0);
  endtask

  task automatic finish_line(input int lr0, input string tag);
    step();
    step();
    check(tag, 32'(lr_cnt - lr0), 32'd1);
    check("idle_busy", 32'(fetch_busy), 32'd0);
    check("cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
  endtask

  initial begin
    int lr0;
    logic [15:0] old_w;
    logic [7:0]  exp_ovr;

    rst_n = 1'b0;
    req_rd_ddr = 1'b0;
    req_ddr_addr_row = '0;
    ddr_rd_ack = 1'b0;
    ddr_rd_data_valid = 1'b0;
    ddr_rd_data = 16'h0;
    linebuf_rd_en = 1'b0;
    linebuf_rd_addr = '0;
    repeat (3) step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    // Row 2 into bank 0
    lr0 = lr_cnt;
    push_cmds(2, NBURST);
    pulse_req(2);
    check("req_latency", 32'(ddr_rd_req), 32'd1);
    check("busy", 32'(fetch_busy), 32'd1);
    fetch(2, 0, 0);
    finish_line(lr0, "lr_row2");
    readback(0, 640);

    // Row 3 into bank 1, bank 0 untouched
    lr0 = lr_cnt;
    push_cmds(3, NBURST);
    pulse_req(3);
    fetch(3, 0, 0);
    finish_line(lr0, "lr_row3");
    readback(0, 640);
    readback(1024, 640);

    // Stray data beats while idle are ignored
    ddr_rd_data_valid = 1'b1;
    ddr_rd_data = 16'hDEAD;
    repeat (4) step();
    ddr_rd_data_valid = 1'b0;
    readback(0, 8);
    readback(1024, 8);

    // Command stalled 20 cycles on the first burst
    lr0 = lr_cnt;
    push_cmds(5, NBURST);
    pulse_req(5);
    fetch(5, 0, 20);
    finish_line(lr0, "lr_row5");
    readback(1024, 640);

    // Abort row 4 after 3 beats of burst 5, restart with row 6
    lr0 = lr_cnt;
    push_cmds(4, 6);
    pulse_req(4);
    for (int b = 0; b < 5; b++) begin
      issue(0);
      beats(4, b * 8, 8, 1'b1);
    end
    issue(0);
    beats(4, 40, 3, 1'b1);
    push_cmds(6, NBURST);
    pulse_req(6);
    check("abort_busy", 32'(fetch_busy), 32'd1);
    beats(4, 43, 5, 1'b0);
    wait_req();
    readback(0, 48);
`ifdef FRAME_LINE_FETCH_OVERRUN_CNT_EN
    exp_ovr = 8'd1;
`else
    exp_ovr = 8'd0;
`endif
    check("ovr_cnt", 32'(fetch_overrun_cnt), 32'(exp_ovr));
    fetch(6, 0, 0);
    finish_line(lr0, "lr_abort");
    readback(0, 640);

    // Same-cycle write and read of address 5 returns old word, then new word
    lr0 = lr_cnt;
    push_cmds(8, NBURST);
    pulse_req(8);
    issue(0);
    beats(8, 0, 5, 1'b1);
    old_w = ref_mem[5];
    ddr_rd_data_valid = 1'b1;
    ddr_rd_data = pat(8, 5);
    ref_mem[5] = ddr_rd_data;
    linebuf_rd_en = 1'b1;
    linebuf_rd_addr = 11'd5;
    step();
    check("rw_old", 32'(linebuf_rd_data), 32'(old_w));
    ddr_rd_data = pat(8, 6);
    ref_mem[6] = ddr_rd_data;
    step();
    check("rw_new", 32'(linebuf_rd_data), 32'(pat(8, 5)));
    linebuf_rd_en = 1'b0;
    beats(8, 7, 1, 1'b1);
    fetch(8, 1, 0);
    finish_line(lr0, "lr_row8");
    readback(0, 16);

    // Reset in the middle of a burst, then a normal fetch
    push_cmds(10, 1);
    pulse_req(10);
    issue(0);
    beats(10, 0, 3, 1'b1);
    rst_n = 1'b0;
    ddr_rd_data_valid = 1'b1;
    ddr_rd_data = 16'hBEEF;
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    ddr_rd_data_valid = 1'b0;
    step();
    check("rst_idle_busy", 32'(fetch_busy), 32'd0);
    lr0 = lr_cnt;
    push_cmds(12, NBURST);
    pulse_req(12);
    check("post_rst_req", 32'(ddr_rd_req), 32'd1);
    fetch(12, 0, 0);
    finish_line(lr0, "lr_row12");
    readback(0, 640);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
